// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit write-only byte driver: one byte per start, EN strobe, execution wait, done pulse.
// Optional LCD_XFER_CNT_EN adds a 16-bit count of completed transfers on xfer_count.
module lcd_hd44780_driver #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned EN_CYC        = 16,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned LONG_EXEC_CYC = 82000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        rs_in,
  input  logic        start,
  output logic        done,
  output logic        busy,
`ifdef LCD_XFER_CNT_EN
  output logic [15:0] xfer_count,
`endif
  output logic [7:0]  LCD_DATA,
  output logic        LCD_RS,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_ON,
  output logic        LCD_BLON
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_t;

  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_LD    = 20'(EN_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] EXEC_LD  = 20'(EXEC_CYC - 1);
  localparam logic [19:0] LONG_LD  = 20'(LONG_EXEC_CYC - 1);

  state_t      state;
  logic [19:0] cnt;
  logic        long_exec;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d[7:1] == 7'b0000001);
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      long_exec <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      LCD_EN    <= 1'b0;
      LCD_DATA  <= 8'h00;
      LCD_RS    <= 1'b0;
`ifdef LCD_XFER_CNT_EN
      xfer_count <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            LCD_DATA  <= data_in;
            LCD_RS    <= rs_in;
            long_exec <= is_long(rs_in, data_in);
            cnt       <= SETUP_LD;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b1;
            cnt    <= EN_LD;
            state  <= PULSE;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= HOLD_LD;
            state  <= HOLD;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= long_exec ? LONG_LD : EXEC_LD;
            state <= WAIT;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
`ifdef LCD_XFER_CNT_EN
            xfer_count <= xfer_count + 16'd1;
`endif
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        default: begin
          LCD_EN <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Self-checking bench for lcd_hd44780_driver: table vectors, corner sequences and a random phase
// checked every cycle against a timeline model (elapsed cycles since the accepted start).
module tb_lcd_hd44780_driver;

  localparam int S = 2;
  localparam int E = 16;
  localparam int H = 2;
  localparam int X = 40;
  localparam int L = 150;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       rs_in;
  logic       start;
  logic       done, busy;
  logic [7:0] LCD_DATA;
  logic       LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON;
`ifdef LCD_XFER_CNT_EN
  logic [15:0] xfer_count;
`endif

  int total = 0;
  int bad   = 0;

  lcd_hd44780_driver #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X), .LONG_EXEC_CYC(L)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .rs_in(rs_in), .start(start),
    .done(done), .busy(busy),
`ifdef LCD_XFER_CNT_EN
    .xfer_count(xfer_count),
`endif
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
    .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transfer is a timeline of m_k edges since its acceptance.
  function automatic bit needs_long(input logic rs, input logic [7:0] d);
    return (rs == 1'b0) && (d inside {8'h01, 8'h02, 8'h03});
  endfunction

  logic        m_active = 1'b0;
  int          m_k = 0;
  int          m_dur = 0;
  logic [7:0]  m_data = 8'h00;
  logic        m_rs = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_data   <= 8'h00;
      m_rs     <= 1'b0;
      m_cnt    <= 16'h0;
    end else if (m_active && m_k < m_dur) begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_dur) m_cnt <= m_cnt + 16'd1;
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_data   <= data_in;
      m_rs     <= rs_in;
      m_dur    <= S + E + H + (needs_long(rs_in, data_in) ? L : X);
    end else begin
      m_active <= 1'b0;
    end
  end

  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", 32'(busy),   32'(m_active && m_k < m_dur));
      check("mon_en",   32'(LCD_EN), 32'(m_active && m_k >= S && m_k < S + E));
      check("mon_done", 32'(done),   32'(m_active && m_k == m_dur));
      check("mon_data", 32'(LCD_DATA), 32'(m_data));
      check("mon_rs",   32'(LCD_RS), 32'(m_rs));
      check("mon_const", {29'd0, LCD_RW, LCD_ON, LCD_BLON}, 32'h3);
`ifdef LCD_XFER_CNT_EN
      check("mon_xfer_count", 32'(xfer_count), 32'(m_cnt));
`endif
    end
  end

  // Pulse start for one cycle and return edges from acceptance to done (-1 on timeout).
  task automatic do_xfer(input logic [7:0] d, input logic rs, output int lat);
    start = 1'b1; data_in = d; rs_in = rs;
    @(negedge clk);
    start = 1'b0; data_in = 8'($urandom); rs_in = 1'($urandom);
    lat = -1;
    for (int k = 0; k < L + 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       rs;
    int         exp_lat;
  } vec_t;

  vec_t vecs[9];
  int   lat, n;
  logic [7:0] en_bytes[$];
  logic [7:0] seq_bytes[3];
  int   idx;
  logic prev_en;

  initial begin
    reset = 1'b1; start = 1'b0; data_in = 8'h00; rs_in = 1'b0;
    vecs[0] = '{8'h41, 1'b1, 60};
    vecs[1] = '{8'h01, 1'b0, 170};
    vecs[2] = '{8'h02, 1'b0, 170};
    vecs[3] = '{8'h38, 1'b0, 60};
    vecs[4] = '{8'h03, 1'b0, 170};
    vecs[5] = '{8'h00, 1'b0, 60};
    vecs[6] = '{8'h01, 1'b1, 60};
    vecs[7] = '{8'h03, 1'b1, 60};
    vecs[8] = '{8'hFF, 1'b0, 60};
    seq_bytes[0] = 8'h38; seq_bytes[1] = 8'h0C; seq_bytes[2] = 8'h06;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_done", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_en",   32'(LCD_EN), 32'h0);
    check("idle_data", 32'(LCD_DATA), 32'h00);
    check("idle_rs",   32'(LCD_RS), 32'h0);

    // Table-driven transfers: latency and latched byte at done.
    foreach (vecs[i]) begin
      do_xfer(vecs[i].data, vecs[i].rs, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_data", i), 32'(LCD_DATA), 32'(vecs[i].data));
      check($sformatf("vec%0d_rs", i), 32'(LCD_RS), 32'(vecs[i].rs));
      repeat (2) @(negedge clk);
    end

    // Start while busy is ignored.
    start = 1'b1; data_in = 8'h0C; rs_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    start = 1'b1; data_in = 8'hFF; rs_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(80, n);
    check("busy_start_dones", 32'(n), 32'd1);
    check("busy_start_data", 32'(LCD_DATA), 32'h0C);
    check("busy_start_rs", 32'(LCD_RS), 32'h0);

    // start held high: back-to-back transfers, byte changed on each done.
    en_bytes.delete();
    idx = 0; prev_en = 1'b0;
    start = 1'b1; data_in = seq_bytes[0]; rs_in = 1'b0;
    for (int k = 0; k < 400 && idx < 3; k++) begin
      @(negedge clk);
      if (LCD_EN && !prev_en) en_bytes.push_back(LCD_DATA);
      prev_en = LCD_EN;
      if (done) begin
        idx++;
        if (idx < 3) data_in = seq_bytes[idx];
        else start = 1'b0;
      end
    end
    check("held_done_count", 32'(idx), 32'd3);
    check("held_en_pulses", 32'(en_bytes.size()), 32'd3);
    for (int i = 0; i < 3 && i < en_bytes.size(); i++)
      check($sformatf("held_byte%0d", i), 32'(en_bytes[i]), 32'(seq_bytes[i]));
    repeat (3) @(negedge clk);

    // Reset during PULSE: EN drops next cycle, no done, next transfer completes.
    start = 1'b1; data_in = 8'h33; rs_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !LCD_EN; k++) @(negedge clk);
    check("pre_reset_en", 32'(LCD_EN), 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_en", 32'(LCD_EN), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    count_dones(80, n);
    check("reset_no_done", 32'(n), 32'd0);
    do_xfer(8'h21, 1'b1, lat);
    check("post_reset_latency", 32'(lat), 32'd60);
`ifdef LCD_XFER_CNT_EN
    @(negedge clk);
    check("post_reset_xfer_count", 32'(xfer_count), 32'd1);
`endif
    repeat (2) @(negedge clk);

    // Random phase: the per-cycle model comparison covers every cycle.
    for (int k = 0; k < 2500; k++) begin
      start   = ($urandom_range(0, 3) == 0);
      data_in = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      rs_in   = 1'($urandom);
      reset   = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (L + 40) @(negedge clk);
    check("final_idle_busy", 32'(busy), 32'h0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_driver.md
Name: lcd_hd44780_driver

Overview:
- Byte-level HD44780 bus driver in 8-bit write-only mode. It sits directly downstream of the LCD init/formatting sequencer.
- It accepts one command or data byte per start pulse, generates the EN strobe with setup/hold timing, and waits out the controller execution time. It then returns a one-cycle done pulse.
- It drives the board LCD pins LCD_DATA, LCD_RS, LCD_RW, LCD_EN, LCD_ON and LCD_BLON.

Parameters:
- SETUP_CYC, 2, cycles RS/DATA are stable with EN low before the EN rise (≥40 ns @50 MHz).
- EN_CYC, 16, cycles EN is held high (≥230 ns).
- HOLD_CYC, 2, cycles EN is low with DATA/RS still held after the EN fall.
- EXEC_CYC, 2000, execution wait for normal commands and data (40 µs @50 MHz).
- LONG_EXEC_CYC, 82000, execution wait for clear/home (1.64 ms). All parameters are ≥1 and < 2^20.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- data_in  in  8  byte to transfer; sampled only when accepted.
- rs_in  in  1  0 = command, 1 = data; sampled with data_in.
- start  in  1  request; accepted only when idle.
- done  out  1  one-cycle pulse when the transfer and its execution wait have completed.
- busy  out  1  high while a transfer is in progress.
- LCD_DATA  out  8  LCD data bus.
- LCD_RS  out  1  register select.
- LCD_RW  out  1  constant 0 (write only).
- LCD_EN  out  1  enable strobe.
- LCD_ON  out  1  constant 1.
- LCD_BLON  out  1  constant 1.

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state IDLE; counter 0.
  - done=0, busy=0, LCD_EN=0, LCD_DATA=8'h00, LCD_RS=0.
  - LCD_RW=0, LCD_ON=1, LCD_BLON=1 at all times.
- Reset mid-transfer: abort immediately, drop EN the next cycle, and emit no done.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. One 20-bit down-counter is shared by all timed states.
- IDLE:
  - If start=1 at edge N: latch data_in→LCD_DATA and rs_in→LCD_RS.
  - Set the long flag = (rs_in==0) && (data_in==8'h01 || data_in[7:1]==7'b0000001).
  - Load counter=SETUP_CYC-1, set busy=1, go to SETUP. All of these are visible from N+1.
- SETUP: EN=0. At counter==0 → EN=1, counter=EN_CYC-1, go to PULSE.
- PULSE: EN=1. At counter==0 → EN=0, counter=HOLD_CYC-1, go to HOLD.
- HOLD: EN=0, DATA/RS held. At counter==0 → counter=(long ? LONG_EXEC_CYC : EXEC_CYC)-1, go to WAIT.
- WAIT: at counter==0 → done=1, busy=0, go to IDLE.
- done: high for exactly one cycle, the first IDLE cycle; cleared automatically the following cycle.
- Latency, start at edge N to done high: SETUP_CYC+EN_CYC+HOLD_CYC+EXEC(or LONG) cycles after N+1.
  - Defaults: done observed in cycle N+2021 (normal) or N+82021 (long).
- start while busy: ignored, not queued. data_in/rs_in changes while busy have no effect.
- start in the done cycle: accepted (the block is in IDLE); done still pulses for exactly that one cycle.
- start held high continuously: back-to-back transfers, one per done.
- LCD_DATA and LCD_RS keep the last transferred value while idle.
- Command 8'h00 with rs=0 uses the normal wait. Data bytes 8'h01–8'h03 (rs=1) use the normal wait.

Optional Feature:
- Macro: LCD_XFER_CNT_EN.
- Defined:
  - Adds output xfer_count[15:0], reset 0.
  - Increments by 1 in the same cycle done is asserted; wraps FFFF→0000.
  - Not incremented for transfers aborted by reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 10 cycles → done=0, busy=0, LCD_EN=0, LCD_DATA=00, LCD_RS=0, LCD_RW=0, LCD_ON=1, LCD_BLON=1.
- Pulse start one cycle with data_in=8'h41, rs_in=1 at edge N → from N+1 LCD_DATA=41 and RS=1. EN rises at N+3 and is high exactly 16 cycles. done is a single-cycle pulse at N+2021; busy is high N+1..N+2020.
- Command 8'h01 (rs=0), then 8'h02, then 8'h38 → done at +82021, +82021 and +2021 respectively. DATA is unchanged during each EN-high window.
- Issue start=1 with 8'h0C; pulse start again with 8'hFF at N+500 → second request ignored; one done only; LCD_DATA stays 0C.
- Hold start=1 continuously with bytes 38, 0C, 06 changed on each done → three EN pulses with the correct bytes. Each new transfer begins the cycle after the previous done.
- Assert reset while in PULSE → EN=0 next cycle, no done. A following start completes normally. With LCD_XFER_CNT_EN, xfer_count counts only the completed transfers.
